// File: rtl/pulse_wave_mc.sv
// Multi-channel wave shaper: turns time-multiplexed phase words into signed
// pulse/saw/triangle samples; per-channel config can be deferred to phase wrap.
module pulse_wave_mc #(
    parameter int unsigned NCH      = 4,
    parameter int unsigned PW       = 32,
    parameter int unsigned WW       = 12,
    parameter int unsigned OW       = 16,
    parameter int unsigned SYNC_UPD = 1,
    parameter int unsigned CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [CW-1:0]        chan,
    input  logic [PW-1:0]        phs,
    input  logic                 cfg_we,
    input  logic [CW-1:0]        cfg_ch,
    input  logic [1:0]           cfg_mode,
    input  logic [WW-1:0]        cfg_width,
    output logic signed [OW-1:0] out,
    output logic                 valid,
    output logic [CW-1:0]        chan_out
);

    localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;
    // Phase slice wide enough for both the pulse compare and the OW+1 shaping bits
    localparam int unsigned SW = (WW > OW + 1) ? WW : OW + 1;

    localparam logic signed [OW-1:0] FS   = {1'b0, {(OW-1){1'b1}}};
    localparam logic signed [OW-1:0] NFS  = -FS;
    localparam logic [OW-1:0]        MINV = {1'b1, {(OW-1){1'b0}}};

    typedef struct packed {
        logic [1:0]    mode;
        logic [WW-1:0] width;
    } cfg_t;

    localparam cfg_t RST_CFG = '{mode: 2'd0, width: WW'(1) << (WW - 1)};

    cfg_t          shadow [NCH];
    cfg_t          active [NCH];
    logic [NCH-1:0] pend;
    logic [NCH-1:0] prev_msb;

    logic          in_ok_c, cfg_ok_c, cfg_hit_c, wrap_c;
    logic [IW-1:0] ci_c, wi_c;
    cfg_t          new_cfg_c, eff_c;

    // Sample acceptance, wrap detection and the config this sample will use
    always_comb begin
        in_ok_c   = ena && (32'(chan) < NCH);
        cfg_ok_c  = cfg_we && (32'(cfg_ch) < NCH);
        ci_c      = IW'(chan);
        wi_c      = IW'(cfg_ch);
        new_cfg_c = {cfg_mode, cfg_width};
        wrap_c    = in_ok_c && prev_msb[ci_c] && !phs[PW-1];
        cfg_hit_c = cfg_ok_c && in_ok_c && (cfg_ch == chan);
        eff_c     = active[ci_c];
        if (wrap_c && pend[ci_c])
            eff_c = shadow[ci_c];
        if (cfg_hit_c && ((SYNC_UPD == 0) || wrap_c))
            eff_c = new_cfg_c;
    end

    // Per-channel config state; sample-side updates win over a same-channel write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                shadow[i] <= RST_CFG;
                active[i] <= RST_CFG;
            end
            pend     <= '0;
            prev_msb <= '0;
        end else begin
            if (cfg_ok_c) begin
                shadow[wi_c] <= new_cfg_c;
                if (SYNC_UPD == 0)
                    active[wi_c] <= new_cfg_c;
                else
                    pend[wi_c] <= 1'b1;
            end
            if (in_ok_c) begin
                prev_msb[ci_c] <= phs[PW-1];
                if (wrap_c) begin
                    active[ci_c] <= eff_c;
                    pend[ci_c]   <= 1'b0;
                end
            end
        end
    end

    logic          s1_valid;
    logic [CW-1:0] s1_ch;
    cfg_t          s1_cfg;
    logic [SW-1:0] s1_slice;

    // Stage 1: effective config and phase slice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_cfg   <= RST_CFG;
            s1_slice <= '0;
        end else begin
            s1_valid <= in_ok_c;
            if (in_ok_c) begin
                s1_ch    <= chan;
                s1_cfg   <= eff_c;
                s1_slice <= phs[PW-1 -: SW];
            end
        end
    end

    logic [WW-1:0]        top_c;
    logic [OW-1:0]        saw_c, tri_t_c, tri_c, raw_c;
    logic signed [OW-1:0] shaped_c;

    // Mode shaping; the most negative code is clamped so output stays symmetric
    always_comb begin
        top_c   = s1_slice[SW-1 -: WW];
        saw_c   = {~s1_slice[SW-1], s1_slice[SW-2 -: OW-1]};
        tri_t_c = s1_slice[SW-2 -: OW] ^ {OW{s1_slice[SW-1]}};
        tri_c   = {~tri_t_c[OW-1], tri_t_c[OW-2:0]};
        case (s1_cfg.mode)
            2'd2:    raw_c = tri_c;
            2'd3:    raw_c = ~saw_c;
            default: raw_c = saw_c;
        endcase
        if (s1_cfg.mode == 2'd0)
            shaped_c = (top_c > s1_cfg.width) ? FS : NFS;
        else
            shaped_c = (raw_c == MINV) ? NFS : $signed(raw_c);
    end

    // Stage 2: registered sample; out/chan_out hold between valids
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            out      <= '0;
            chan_out <= '0;
        end else begin
            valid <= s1_valid;
            if (s1_valid) begin
                out      <= shaped_c;
                chan_out <= s1_ch;
            end
        end
    end

    if (PW > SW) begin : g_unused
        logic unused_phs_lsbs;
        assign unused_phs_lsbs = ^phs[PW-SW-1:0];
    end

endmodule

// File: tb/tb_pulse_wave_mc.sv
// Directed bench for pulse_wave_mc: a SYNC_UPD=1 instance drives most steps,
// a SYNC_UPD=0 instance on the same inputs covers immediate config updates.
module tb_pulse_wave_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ena = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  chan = '0;
    logic [2:0]  cfg_ch = '0;
    logic [31:0] phs = '0;
    logic [1:0]  cfg_mode = '0;
    logic [11:0] cfg_width = '0;

    logic signed [15:0] out_s, out_a;
    logic               valid_s, valid_a;
    logic [2:0]         chout_s, chout_a;

    int checks = 0;
    int errors = 0;

    logic [2:0]  rr_ch  [10] = '{3'd0, 3'd1, 3'd5, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd5, 3'd3};
    logic [31:0] rr_ph  [10] = '{32'h2000_0000, 32'h2000_0000, 32'h2000_0000, 32'h2000_0000,
                                 32'h2000_0000, 32'hE000_0000, 32'hE000_0000, 32'hE000_0000,
                                 32'hE000_0000, 32'hE000_0000};
    logic        rr_vld [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] rr_exp [10] = '{16'h5FFF, 16'hC000, 16'h0000, 16'h8001, 16'hA000,
                                 16'h9FFF, 16'hBFFF, 16'h7FFF, 16'h0000, 16'h6000};

    always #5 clk = ~clk;

    pulse_wave_mc #(.NCH(4), .PW(32), .WW(12), .OW(16), .SYNC_UPD(1), .CW(3)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .chan(chan), .phs(phs),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_width(cfg_width),
        .out(out_s), .valid(valid_s), .chan_out(chout_s)
    );

    pulse_wave_mc #(.NCH(4), .PW(32), .WW(12), .OW(16), .SYNC_UPD(0), .CW(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .chan(chan), .phs(phs),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_width(cfg_width),
        .out(out_a), .valid(valid_a), .chan_out(chout_a)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; returns 1 time unit after the edge
    task automatic cyc(input logic e, input logic [2:0] ch, input logic [31:0] ph,
                       input logic we, input logic [1:0] wm, input logic [11:0] ww);
        ena = e; chan = ch; phs = ph;
        cfg_we = we; cfg_ch = ch; cfg_mode = wm; cfg_width = ww;
        @(posedge clk);
        #1;
        ena = 1'b0; cfg_we = 1'b0;
    endtask

    // Single sample (optionally with same-cycle config write), checked at latency 2
    task automatic samp(input string tag, input logic [2:0] ch, input logic [31:0] ph,
                        input logic we, input logic [1:0] wm, input logic [11:0] ww,
                        input logic [15:0] exp);
        cyc(1'b1, ch, ph, we, wm, ww);
        cyc(1'b0, 3'd0, 32'd0, 1'b0, 2'd0, 12'd0);
        chk({tag, "_valid"}, 32'(valid_s), 32'd1);
        chk({tag, "_chan"}, 32'(chout_s), 32'(ch));
        chk({tag, "_out"}, 32'($unsigned(out_s)), 32'(exp));
    endtask

    initial begin
        #2 rst_n = 1'b0;
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 3'd0, 32'hC000_0000, 1'b0, 2'd0, 12'd0);
        chk("rst_valid", 32'(valid_s), 32'd0);
        chk("rst_out", 32'($unsigned(out_s)), 32'd0);
        chk("rst_chan", 32'(chout_s), 32'd0);
        chk("rst_valid_a", 32'(valid_a), 32'd0);
        rst_n = 1'b1;

        // First sample: latency 2, default 50% threshold
        cyc(1'b1, 3'd0, 32'hC000_0000, 1'b0, 2'd0, 12'd0);
        chk("lat1_valid", 32'(valid_s), 32'd0);
        cyc(1'b0, 3'd0, 32'd0, 1'b0, 2'd0, 12'd0);
        chk("lat2_valid", 32'(valid_s), 32'd1);
        chk("lat2_out", 32'($unsigned(out_s)), 32'h7FFF);
        chk("lat2_chan", 32'(chout_s), 32'd0);
        cyc(1'b0, 3'd0, 32'd0, 1'b0, 2'd0, 12'd0);
        chk("hold_valid", 32'(valid_s), 32'd0);
        chk("hold_out", 32'($unsigned(out_s)), 32'h7FFF);

        // ch1 saw up then triangle, each taking effect at a wrap
        cyc(1'b0, 3'd1, 32'd0, 1'b1, 2'd1, 12'h800);
        samp("ch1_nowrap", 3'd1, 32'h8000_0000, 1'b0, 2'd0, 12'd0, 16'h8001);
        samp("saw_lo",     3'd1, 32'h0000_0000, 1'b0, 2'd0, 12'd0, 16'h8001);
        samp("saw_mid",    3'd1, 32'h8000_0000, 1'b0, 2'd0, 12'd0, 16'h0000);
        samp("saw_hi",     3'd1, 32'hFFFF_FFFF, 1'b0, 2'd0, 12'd0, 16'h7FFF);
        cyc(1'b0, 3'd1, 32'd0, 1'b1, 2'd2, 12'h800);
        samp("tri_lo",     3'd1, 32'h0000_0000, 1'b0, 2'd0, 12'd0, 16'h8001);
        samp("tri_mid",    3'd1, 32'h4000_0000, 1'b0, 2'd0, 12'd0, 16'h0000);
        samp("tri_hi",     3'd1, 32'h7FFF_FFFF, 1'b0, 2'd0, 12'd0, 16'h7FFF);

        // ch2: two pending writes, only the last one lands at the wrap
        samp("s_0",    3'd2, 32'h0000_0000, 1'b0, 2'd0, 12'd0,   16'h8001);
        samp("s_3",    3'd2, 32'h3000_0000, 1'b1, 2'd0, 12'hF00, 16'h8001);
        samp("s_6",    3'd2, 32'h6000_0000, 1'b1, 2'd0, 12'hC00, 16'h8001);
        samp("s_9",    3'd2, 32'h9000_0000, 1'b0, 2'd0, 12'd0,   16'h7FFF);
        samp("s_f",    3'd2, 32'hF000_0000, 1'b0, 2'd0, 12'd0,   16'h7FFF);
        samp("s_wrap", 3'd2, 32'h0000_0000, 1'b0, 2'd0, 12'd0,   16'h8001);
        samp("s_a",    3'd2, 32'hA000_0000, 1'b0, 2'd0, 12'd0,   16'h8001);
        samp("s_d",    3'd2, 32'hD000_0000, 1'b0, 2'd0, 12'd0,   16'h7FFF);

        // ch3: write in the same cycle as a wrap applies to that very sample
        samp("w_pre",   3'd3, 32'h8000_0000, 1'b0, 2'd0, 12'd0,   16'h8001);
        samp("w_wrap",  3'd3, 32'h0000_0000, 1'b1, 2'd0, 12'hFFF, 16'h8001);
        samp("w_next",  3'd3, 32'hF000_0000, 1'b0, 2'd0, 12'd0,   16'h8001);
        samp("wm_wrap", 3'd3, 32'h4000_0000, 1'b1, 2'd1, 12'hFFF, 16'hC000);
        samp("wm_next", 3'd3, 32'h8000_0000, 1'b0, 2'd0, 12'd0,   16'h0000);

        // Back-to-back round robin with an out-of-range channel mixed in
        cyc(1'b0, 3'd0, 32'd0, 1'b1, 2'd3, 12'h800);
        for (int i = 0; i <= 10; i++) begin
            if (i < 10)
                cyc(1'b1, rr_ch[i], rr_ph[i], 1'b0, 2'd0, 12'd0);
            else
                cyc(1'b0, 3'd0, 32'd0, 1'b0, 2'd0, 12'd0);
            if (i > 0) begin
                chk($sformatf("rr%0d_valid", i - 1), 32'(valid_s), 32'(rr_vld[i-1]));
                if (rr_vld[i-1]) begin
                    chk($sformatf("rr%0d_chan", i - 1), 32'(chout_s), 32'(rr_ch[i-1]));
                    chk($sformatf("rr%0d_out", i - 1), 32'($unsigned(out_s)), 32'(rr_exp[i-1]));
                end
            end
        end

        // Reset mid-flight flushes the sample already in the pipeline
        cyc(1'b1, 3'd0, 32'h9000_0000, 1'b0, 2'd0, 12'd0);
        rst_n = 1'b0;
        cyc(1'b0, 3'd0, 32'd0, 1'b0, 2'd0, 12'd0);
        chk("flush_valid", 32'(valid_s), 32'd0);
        chk("flush_out", 32'($unsigned(out_s)), 32'd0);
        chk("flush_valid_a", 32'(valid_a), 32'd0);
        rst_n = 1'b1;

        // Immediate update instance versus deferred update instance
        cyc(1'b1, 3'd0, 32'h9000_0000, 1'b0, 2'd0, 12'd0);
        cyc(1'b0, 3'd0, 32'd0, 1'b0, 2'd0, 12'd0);
        chk("imm_pre_valid", 32'(valid_a), 32'd1);
        chk("imm_pre_out", 32'($unsigned(out_a)), 32'h7FFF);
        cyc(1'b0, 3'd0, 32'd0, 1'b1, 2'd0, 12'hFFF);
        cyc(1'b1, 3'd0, 32'hA000_0000, 1'b0, 2'd0, 12'd0);
        cyc(1'b0, 3'd0, 32'd0, 1'b0, 2'd0, 12'd0);
        chk("imm_valid", 32'(valid_a), 32'd1);
        chk("imm_chan", 32'(chout_a), 32'd0);
        chk("imm_out", 32'($unsigned(out_a)), 32'h8001);
        chk("defer_out", 32'($unsigned(out_s)), 32'h7FFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
